// File: rtl/branch_predict_ctrl.sv
// Direct-mapped BTB with 2-bit counters plus mispredict redirect and stats.
// Ports: clock/reset, IF lookup (IF_pc, IF_isBranch -> IF_predTaken,
// IF_predTarget), ID resolve (ID_* -> Mispredict, Redirect_pc), counters.
module branch_predict_ctrl #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IF_pc,
  input  logic        IF_isBranch,
  output logic        IF_predTaken,
  output logic [31:0] IF_predTarget,
  input  logic        ID_update,
  input  logic [31:0] ID_pc,
  input  logic        ID_taken,
  input  logic [31:0] ID_target,
  input  logic        ID_predTaken,
  input  logic [31:0] ID_predTarget,
  output logic        Mispredict,
  output logic [31:0] Redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] miss_cnt
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]               valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_BITS-1:0] tag_q, tag_d;
  logic [ENTRIES-1:0][31:0]         target_q, target_d;
  logic [ENTRIES-1:0][1:0]          ctr_q, ctr_d;
  logic [31:0]                      branch_cnt_q, branch_cnt_d;
  logic [31:0]                      miss_cnt_q, miss_cnt_d;

  logic [INDEX_BITS-1:0] if_idx, id_idx;
  logic [TAG_BITS-1:0]   if_tag, id_tag;
  logic                  if_hit, id_hit;
  logic                  misp;
  logic                  unused_pc_bits;

  assign unused_pc_bits = ^IF_pc[1:0];

  assign if_idx = IF_pc[INDEX_BITS+1:2];
  assign if_tag = IF_pc[31:INDEX_BITS+2];
  assign id_idx = ID_pc[INDEX_BITS+1:2];
  assign id_tag = ID_pc[31:INDEX_BITS+2];

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign id_hit = valid_q[id_idx] && (tag_q[id_idx] == id_tag);

  // Lookup reads the registered table, so a same-cycle update is
  // only seen from the following cycle.
  assign IF_predTaken  = !reset && IF_isBranch && if_hit
                         && ctr_q[if_idx][1];
  assign IF_predTarget = IF_predTaken ? target_q[if_idx] : 32'd0;

  assign misp = !reset && ID_update
                && ((ID_taken != ID_predTaken)
                    || (ID_taken && (ID_predTarget != ID_target)));

  assign Mispredict  = misp;
  assign Redirect_pc = !misp    ? 32'd0 :
                       ID_taken ? ID_target : ID_pc + 32'd4;

  assign branch_cnt = branch_cnt_q;
  assign miss_cnt   = miss_cnt_q;

  always_comb begin
    valid_d      = valid_q;
    tag_d        = tag_q;
    target_d     = target_q;
    ctr_d        = ctr_q;
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (ID_update) begin
      if (ID_taken) begin
        target_d[id_idx] = ID_target;
        if (id_hit) begin
          if (ctr_q[id_idx] != 2'b11)
            ctr_d[id_idx] = ctr_q[id_idx] + 2'd1;
        end else begin
          // Allocate, evicting whatever aliased into this slot.
          valid_d[id_idx] = 1'b1;
          tag_d[id_idx]   = id_tag;
          ctr_d[id_idx]   = 2'b10;
        end
      end else if (id_hit && (ctr_q[id_idx] != 2'b00)) begin
        ctr_d[id_idx] = ctr_q[id_idx] - 2'd1;
      end
      if (branch_cnt_q != 32'hFFFF_FFFF)
        branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (misp && (miss_cnt_q != 32'hFFFF_FFFF))
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q      <= '0;
      tag_q        <= '0;
      target_q     <= '0;
      ctr_q        <= {ENTRIES{2'b01}};
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      target_q     <= target_d;
      ctr_q        <= ctr_d;
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: directed scenarios then random traffic
// checked against a table-level behavioural model.
module tb_branch_predict_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] IF_pc;
  logic        IF_isBranch;
  logic        IF_predTaken;
  logic [31:0] IF_predTarget;
  logic        ID_update;
  logic [31:0] ID_pc;
  logic        ID_taken;
  logic [31:0] ID_target;
  logic        ID_predTaken;
  logic [31:0] ID_predTarget;
  logic        Mispredict;
  logic [31:0] Redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  branch_predict_ctrl dut (
    .clock(clock), .reset(reset),
    .IF_pc(IF_pc), .IF_isBranch(IF_isBranch),
    .IF_predTaken(IF_predTaken), .IF_predTarget(IF_predTarget),
    .ID_update(ID_update), .ID_pc(ID_pc), .ID_taken(ID_taken),
    .ID_target(ID_target), .ID_predTaken(ID_predTaken),
    .ID_predTarget(ID_predTarget),
    .Mispredict(Mispredict), .Redirect_pc(Redirect_pc),
    .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  // Behavioural model: 16 entries, counters as plain integers.
  bit          m_valid[16];
  int unsigned m_tag[16];
  int unsigned m_tgt[16];
  int          m_ctr[16];
  longint      m_bc, m_mc;

  function automatic int idx_of(input int unsigned pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic int unsigned tag_of(input int unsigned pc);
    return pc / 64;
  endfunction

  function automatic bit m_hit(input int unsigned pc);
    return m_valid[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
  endfunction

  function automatic bit m_pred(input int unsigned pc, input bit isb);
    return !reset && isb && m_hit(pc) && m_ctr[idx_of(pc)] >= 2;
  endfunction

  function automatic bit m_misp();
    if (reset || !ID_update) return 1'b0;
    if (ID_taken != ID_predTaken) return 1'b1;
    return ID_taken && ID_predTarget != ID_target;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input bit rst, input logic [31:0] ipc,
                       input bit isb, input bit upd,
                       input logic [31:0] dpc, input bit tk,
                       input logic [31:0] tgt, input bit ptk,
                       input logic [31:0] ptgt);
    logic [31:0] e_tgt, e_red;
    bit          e_pt, e_mp;
    reset = rst; IF_pc = ipc; IF_isBranch = isb;
    ID_update = upd; ID_pc = dpc; ID_taken = tk;
    ID_target = tgt; ID_predTaken = ptk; ID_predTarget = ptgt;
    #2;
    e_pt  = m_pred(ipc, isb);
    e_tgt = e_pt ? m_tgt[idx_of(ipc)] : 32'd0;
    e_mp  = m_misp();
    e_red = !e_mp ? 32'd0 : (tk ? tgt : dpc + 32'd4);
    chk("predTaken", {31'd0, IF_predTaken}, {31'd0, e_pt});
    chk("predTarget", IF_predTarget, e_tgt);
    chk("mispredict", {31'd0, Mispredict}, {31'd0, e_mp});
    chk("redirect", Redirect_pc, e_red);
  endtask

  task automatic tick();
    bit mp;
    int i;
    int unsigned pc;
    mp = m_misp();
    @(posedge clock);
    if (reset) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 0; m_ctr[k] = 1; m_tag[k] = 0; m_tgt[k] = 0;
      end
      m_bc = 0; m_mc = 0;
    end else if (ID_update) begin
      pc = ID_pc;
      i  = idx_of(pc);
      if (ID_taken) begin
        if (m_hit(pc)) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        end else begin
          m_valid[i] = 1; m_tag[i] = tag_of(pc); m_ctr[i] = 2;
        end
        m_tgt[i] = ID_target;
      end else if (m_hit(pc)) begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
      if (m_bc < 64'hFFFF_FFFF) m_bc++;
      if (mp && m_mc < 64'hFFFF_FFFF) m_mc++;
    end
    #1;
    chk("branch_cnt", branch_cnt, m_bc[31:0]);
    chk("miss_cnt", miss_cnt, m_mc[31:0]);
  endtask

  task automatic lookup(input logic [31:0] pc);
    apply(0, pc, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] rpc, dpc, rt, pt;
    bit          tk, ptk, upd, rst;

    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    lookup(32'h0040_0010);
    chk("tp_reset_pt", {31'd0, IF_predTaken}, 32'd0);
    chk("tp_reset_tgt", IF_predTarget, 32'd0);
    chk("tp_reset_bc", branch_cnt, 32'd0);
    chk("tp_reset_mc", miss_cnt, 32'd0);
    tick();

    apply(0, 0, 0, 1, 32'h0040_0010, 1, 32'h0040_0040, 0, 0);
    chk("tp_alloc_mp", {31'd0, Mispredict}, 32'd1);
    chk("tp_alloc_red", Redirect_pc, 32'h0040_0040);
    tick();

    lookup(32'h0040_0010);
    chk("tp_after_pt", {31'd0, IF_predTaken}, 32'd1);
    chk("tp_after_tgt", IF_predTarget, 32'h0040_0040);
    chk("tp_after_bc", branch_cnt, 32'd1);
    chk("tp_after_mc", miss_cnt, 32'd1);
    tick();

    repeat (2) begin
      apply(0, 0, 0, 1, 32'h0040_0010, 1, 32'h0040_0040,
            1, 32'h0040_0040);
      chk("tp_correct_mp", {31'd0, Mispredict}, 32'd0);
      tick();
    end

    apply(0, 0, 0, 1, 32'h0040_0010, 0, 32'h0040_0040,
          1, 32'h0040_0040);
    chk("tp_nt_mp", {31'd0, Mispredict}, 32'd1);
    chk("tp_nt_red", Redirect_pc, 32'h0040_0014);
    tick();
    lookup(32'h0040_0010);
    chk("tp_ctr2_pt", {31'd0, IF_predTaken}, 32'd1);
    tick();

    apply(0, 0, 0, 1, 32'h0040_0010, 0, 32'h0040_0040,
          1, 32'h0040_0040);
    tick();
    lookup(32'h0040_0010);
    chk("tp_ctr1_pt", {31'd0, IF_predTaken}, 32'd0);
    tick();

    apply(0, 0, 0, 1, 32'h0040_0050, 1, 32'h0040_0100, 0, 0);
    tick();
    lookup(32'h0040_0010);
    chk("tp_alias_old", {31'd0, IF_predTaken}, 32'd0);
    tick();
    lookup(32'h0040_0050);
    chk("tp_alias_new", {31'd0, IF_predTaken}, 32'd1);
    chk("tp_alias_tgt", IF_predTarget, 32'h0040_0100);
    tick();

    apply(0, 32'h0040_001C, 1, 1, 32'h0040_001C, 1,
          32'h0040_0200, 0, 0);
    chk("tp_rbw_same", {31'd0, IF_predTaken}, 32'd0);
    tick();
    lookup(32'h0040_001C);
    chk("tp_rbw_next", {31'd0, IF_predTaken}, 32'd1);
    tick();

    apply(1, 32'h0040_0050, 1, 1, 32'h0040_0050, 0, 0,
          1, 32'h0040_0100);
    chk("tp_rst_mp", {31'd0, Mispredict}, 32'd0);
    tick();
    lookup(32'h0040_0050);
    chk("tp_rst_pt", {31'd0, IF_predTaken}, 32'd0);
    chk("tp_rst_bc", branch_cnt, 32'd0);
    chk("tp_rst_mc", miss_cnt, 32'd0);
    tick();

    // Random traffic over a few tags and all indexes to force aliasing.
    for (int n = 0; n < 600; n++) begin
      rpc = 32'h0040_0000 | ($urandom_range(0, 3) << 6)
            | ($urandom_range(0, 15) << 2);
      dpc = 32'h0040_0000 | ($urandom_range(0, 3) << 6)
            | ($urandom_range(0, 15) << 2);
      if (n % 97 == 5) dpc = 32'hFFFF_FFFC;
      upd = ($urandom_range(0, 3) != 0);
      tk  = $urandom_range(0, 1);
      rt  = 32'h0040_0000 | ($urandom_range(0, 7) << 4);
      if ($urandom_range(0, 2) != 0) begin
        ptk = m_pred(dpc, 1);
        pt  = ptk ? m_tgt[idx_of(dpc)] : 32'd0;
      end else begin
        ptk = $urandom_range(0, 1);
        pt  = 32'h0040_0000 | ($urandom_range(0, 7) << 4);
      end
      rst = ($urandom_range(0, 99) == 0);
      apply(rst, rpc, $urandom_range(0, 4) != 0, upd, dpc, tk, rt,
            ptk, pt);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
